// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - requester-side and memory-side bus bundle for memory_arbiter
interface memory_arbiter_if #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [NUM_PORTS-1:0]               port_memory_enable;
    logic [NUM_PORTS-1:0]               port_memory_command;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] port_read_memory_address;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] port_write_memory_address;
    logic [NUM_PORTS*DATA_WIDTH-1:0]    port_write_memory_data;
    logic [NUM_PORTS*DATA_WIDTH-1:0]    port_write_memory_mask;
    logic [NUM_PORTS-1:0]               port_memory_ready;
    logic [NUM_PORTS-1:0]               port_memory_valid;
    logic [DATA_WIDTH-1:0]              port_read_memory_data;

    logic                               memory_ready;
    logic                               memory_valid;
    logic [DATA_WIDTH-1:0]              read_memory_data;
    logic                               memory_enable;
    logic                               memory_command;
    logic [ADDRESS_WIDTH-1:0]           read_memory_address;
    logic [ADDRESS_WIDTH-1:0]           write_memory_address;
    logic [DATA_WIDTH-1:0]              write_memory_data;
    logic [DATA_WIDTH-1:0]              write_memory_mask;

    modport slave (
        input  port_memory_enable, port_memory_command, port_read_memory_address,
               port_write_memory_address, port_write_memory_data, port_write_memory_mask,
        output port_memory_ready, port_memory_valid, port_read_memory_data,
        input  memory_ready, memory_valid, read_memory_data,
        output memory_enable, memory_command, read_memory_address,
               write_memory_address, write_memory_data, write_memory_mask
    );

    modport master (
        output port_memory_enable, port_memory_command, port_read_memory_address,
               port_write_memory_address, port_write_memory_data, port_write_memory_mask,
        input  port_memory_ready, port_memory_valid, port_read_memory_data,
        output memory_ready, memory_valid, read_memory_data,
        input  memory_enable, memory_command, read_memory_address,
               write_memory_address, write_memory_data, write_memory_mask
    );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter sharing one memory port among NUM_PORTS requesters
module memory_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int GRANT_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    memory_arbiter_if.slave        bus,
    output logic [GRANT_WIDTH-1:0] debug_grant,
    output logic [1:0]             debug_state
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCKED    = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [GRANT_WIDTH-1:0] last_q, last_next, owner_q, owner_next;
    logic [GRANT_WIDTH-1:0] winner, sel, cand_idx;
    logic                   found, active;

    logic [ADDRESS_WIDTH-1:0] ra_arr [NUM_PORTS];
    logic [ADDRESS_WIDTH-1:0] wa_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0]    wd_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0]    wm_arr [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign ra_arr[i] = bus.port_read_memory_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign wa_arr[i] = bus.port_write_memory_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign wd_arr[i] = bus.port_write_memory_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign wm_arr[i] = bus.port_write_memory_mask[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from lowest to highest priority so the last hit is the port right after last_q.
    always_comb begin
        winner   = last_q;
        found    = 1'b0;
        cand_idx = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand_idx = GRANT_WIDTH'((int'(last_q) + k) % NUM_PORTS);
            if (bus.port_memory_enable[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel    = (state == IDLE) ? winner : owner_q;
        active = 1'b0;
        if (reset) begin
            if (state == IDLE)        active = found;
            else if (state == LOCKED) active = bus.port_memory_enable[sel];
        end

        bus.memory_enable        = active;
        bus.memory_command       = 1'b0;
        bus.read_memory_address  = '0;
        bus.write_memory_address = '0;
        bus.write_memory_data    = '0;
        bus.write_memory_mask    = '0;
        bus.port_memory_ready    = '0;
        if (active) begin
            bus.memory_command       = bus.port_memory_command[sel];
            bus.read_memory_address  = ra_arr[sel];
            bus.write_memory_address = wa_arr[sel];
            bus.write_memory_data    = wd_arr[sel];
            bus.write_memory_mask    = wm_arr[sel];
            if (bus.memory_ready) bus.port_memory_ready = NUM_PORTS'(1) << sel;
        end

        bus.port_memory_valid = '0;
        if (reset && state == READ_WAIT && bus.memory_valid)
            bus.port_memory_valid = NUM_PORTS'(1) << owner_q;
        bus.port_read_memory_data = bus.read_memory_data;

        debug_grant = sel;
        debug_state = state;
    end

    always_comb begin
        state_next = state;
        last_next  = last_q;
        owner_next = owner_q;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_next = winner;
                    if (!bus.memory_ready)                    state_next = LOCKED;
                    else if (bus.port_memory_command[winner]) last_next  = winner;
                    else                                      state_next = READ_WAIT;
                end
            end
            LOCKED: begin
                if (!bus.port_memory_enable[owner_q]) begin
                    state_next = IDLE;
                    last_next  = owner_q;
                end else if (bus.memory_ready) begin
                    if (bus.port_memory_command[owner_q]) begin
                        state_next = IDLE;
                        last_next  = owner_q;
                    end else begin
                        state_next = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (bus.memory_valid) begin
                    state_next = IDLE;
                    last_next  = owner_q;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            last_q  <= GRANT_WIDTH'(NUM_PORTS - 1);
            owner_q <= '0;
        end else begin
            state   <= state_next;
            last_q  <= last_next;
            owner_q <= owner_next;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed and randomized scoreboard bench for memory_arbiter
module tb_memory_arbiter;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GW = $clog2(NP);

    typedef struct {
        bit            cmd;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] wm;
    } txn_t;
    typedef struct { int port; txn_t t; } exp_cmd_t;
    typedef struct { int port; logic [DW-1:0] data; } exp_rd_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [GW-1:0] debug_grant;
    logic [1:0]    debug_state;

    memory_arbiter_if #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_arbiter #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .debug_grant (debug_grant),
        .debug_state (debug_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    txn_t     pq [NP][$];
    exp_cmd_t exp_cmd_q[$];
    exp_rd_t  exp_rd_q[$];
    logic [DW-1:0] wd_tab [NP];
    logic [DW-1:0] wm_tab [NP];

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic txn_t mk(bit cmd, logic [AW-1:0] ra, logic [AW-1:0] wa,
                                logic [DW-1:0] wd, logic [DW-1:0] wm);
        txn_t t;
        t.cmd = cmd; t.ra = ra; t.wa = wa; t.wd = wd; t.wm = wm;
        return t;
    endfunction

    function automatic logic [DW-1:0] mem_fn(logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int rr_pick(int last, logic [NP-1:0] en);
        for (int k = 1; k <= NP; k++)
            if (en[(last + k) % NP]) return (last + k) % NP;
        return -1;
    endfunction

    task automatic put_port(int p, bit en, txn_t t);
        bus.port_memory_enable[p]                = en;
        bus.port_memory_command[p]               = t.cmd;
        bus.port_read_memory_address[p*AW +: AW]  = t.ra;
        bus.port_write_memory_address[p*AW +: AW] = t.wa;
        bus.port_write_memory_data[p*DW +: DW]    = t.wd;
        bus.port_write_memory_mask[p*DW +: DW]    = t.wm;
    endtask

    function automatic txn_t wr(int p);
        return mk(1'b1, 32'h0, 32'h1000 + 32'(4 * p), wd_tab[p], wm_tab[p]);
    endfunction

    task automatic all_off();
        for (int p = 0; p < NP; p++) put_port(p, 1'b0, mk(1'b0, 0, 0, 0, 0));
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT shows an accepted command or a read valid.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.memory_enable && bus.memory_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    check("unexpected_accept", 1, 0);
                end else begin
                    exp_cmd_t e;
                    e = exp_cmd_q.pop_front();
                    check("sb_grant_ready", bus.port_memory_ready, 64'(1) << e.port);
                    check("sb_command", bus.memory_command, e.t.cmd);
                    check("sb_read_addr", bus.read_memory_address, e.t.ra);
                    check("sb_write_addr", bus.write_memory_address, e.t.wa);
                    check("sb_write_data", bus.write_memory_data, e.t.wd);
                    check("sb_write_mask", bus.write_memory_mask, e.t.wm);
                end
            end
            if (bus.port_memory_valid != '0) begin
                if (exp_rd_q.size() == 0) begin
                    check("unexpected_valid", bus.port_memory_valid, 0);
                end else begin
                    exp_rd_t r;
                    r = exp_rd_q.pop_front();
                    check("sb_valid_port", bus.port_memory_valid, 64'(1) << r.port);
                    check("sb_read_data", bus.port_read_memory_data, r.data);
                end
            end
        end
    end

    initial begin
        logic [NP-1:0] acc;
        bit            presenting [NP];
        int            m_last, m_owner, rd_cnt, cyc, pending;
        bit            m_reading;
        txn_t          m_txn;
        logic [DW-1:0] rd_data;
        exp_cmd_t      ec;
        exp_rd_t       er;

        wd_tab[0] = 32'h1111_0000; wd_tab[1] = 32'hDEAD_BEEF; wd_tab[2] = 32'h2222_0002;
        wm_tab[0] = 32'h0000_FFFF; wm_tab[1] = 32'hFFFF_FFFF; wm_tab[2] = 32'hFF00_FF00;
        bus.memory_ready = 1'b1;
        bus.memory_valid = 1'b0;
        bus.read_memory_data = '0;
        for (int p = 0; p < NP; p++) put_port(p, 1'b1, wr(p));

        // Reset held with every port requesting
        repeat (2) begin
            @(negedge clk);
            check("rst_mem_enable", bus.memory_enable, 0);
            check("rst_ready", bus.port_memory_ready, 0);
            check("rst_valid", bus.port_memory_valid, 0);
            check("rst_state", debug_state, 0);
        end
        @(posedge clk); #1 reset = 1'b1;

        // Back-to-back writes rotate 0,1,2,0,1,2
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_grant", debug_grant, i % NP);
            check("rr_ready", bus.port_memory_ready, 64'(1) << (i % NP));
            check("rr_waddr", bus.write_memory_address, 32'h1000 + 32'(4 * (i % NP)));
            check("rr_wdata", bus.write_memory_data, wd_tab[i % NP]);
            check("rr_wmask", bus.write_memory_mask, wm_tab[i % NP]);
        end

        // Lock to port 0 while port 1 waits
        @(posedge clk); #1;
        put_port(2, 1'b0, wr(2));
        bus.memory_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lock_grant", debug_grant, 0);
            check("lock_state", debug_state, (k == 0) ? 0 : 1);
            check("lock_ready", bus.port_memory_ready, 0);
            check("lock_enable", bus.memory_enable, 1);
        end
        @(posedge clk); #1 bus.memory_ready = 1'b1;
        @(negedge clk);
        check("lock_accept", bus.port_memory_ready, 3'b001);
        @(posedge clk); #1 put_port(0, 1'b0, wr(0));
        @(negedge clk);
        check("after_lock_grant", debug_grant, 1);
        check("after_lock_ready", bus.port_memory_ready, 3'b010);

        // Port 2 locks then withdraws
        @(posedge clk); #1;
        put_port(1, 1'b0, wr(1));
        put_port(2, 1'b1, wr(2));
        bus.memory_ready = 1'b0;
        @(negedge clk);
        check("p2_grant", debug_grant, 2);
        @(posedge clk); #1;
        put_port(2, 1'b0, wr(2));
        put_port(0, 1'b1, wr(0));
        put_port(1, 1'b1, wr(1));
        @(negedge clk);
        check("drop_enable", bus.memory_enable, 0);
        check("drop_state", debug_state, 1);
        @(posedge clk); #1 bus.memory_ready = 1'b1;
        @(negedge clk);
        check("drop_next_grant", debug_grant, 0);
        check("drop_next_ready", bus.port_memory_ready, 3'b001);

        // Read abandoned by reset; late valid is discarded
        @(posedge clk); #1;
        all_off();
        put_port(1, 1'b1, mk(1'b0, 32'h100, 32'h0, 32'h0, 32'h0));
        @(negedge clk);
        check("rd_command", bus.memory_command, 0);
        check("rd_addr", bus.read_memory_address, 32'h100);
        check("rd_ready", bus.port_memory_ready, 3'b010);
        @(posedge clk); #1 all_off();
        @(negedge clk);
        check("rd_wait_state", debug_state, 2);
        check("rd_wait_enable", bus.memory_enable, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.memory_valid = 1'b1;
        bus.read_memory_data = 32'h1234_5678;
        @(negedge clk);
        check("late_valid", bus.port_memory_valid, 0);
        check("late_state", debug_state, 0);
        check("rdata_broadcast", bus.port_read_memory_data, 32'h1234_5678);
        @(posedge clk); #1 bus.memory_valid = 1'b0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            int p;
            p = $urandom_range(0, NP - 1);
            pq[p].push_back(mk(1'($urandom_range(0, 1)), {$urandom} & 32'hFFFF_FFFC,
                               {$urandom} & 32'hFFFF_FFFC, $urandom, $urandom));
        end
        reset = 1'b0;
        bus.memory_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int p = 0; p < NP; p++) presenting[p] = 1'b0;
        m_last = NP - 1; m_owner = -1; m_reading = 1'b0; rd_cnt = 0; rd_data = '0; cyc = 0;
        m_txn = mk(1'b0, 0, 0, 0, 0);
        mon_on = 1'b1;
        pending = 60;
        while ((pending > 0 || m_reading || m_owner >= 0) && cyc < 6000) begin
            cyc++;
            @(negedge clk);
            for (int p = 0; p < NP; p++) acc[p] = bus.port_memory_ready[p] & bus.port_memory_enable[p];
            @(posedge clk); #1;
            pending = 0;
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    if (pq[p].size() > 0) pq[p].delete(0);
                    presenting[p] = 1'b0;
                end
                if (pq[p].size() > 0 && (presenting[p] || $urandom_range(0, 3) != 0)) begin
                    presenting[p] = 1'b1;
                    put_port(p, 1'b1, pq[p][0]);
                end else begin
                    put_port(p, 1'b0, mk(1'b0, 0, 0, 0, 0));
                end
                pending += pq[p].size();
            end
            bus.memory_ready = ($urandom_range(0, 3) != 0);
            bus.memory_valid = 1'b0;
            bus.read_memory_data = $urandom;
            if (m_reading) begin
                if (rd_cnt == 0) begin
                    bus.memory_valid = 1'b1;
                    bus.read_memory_data = rd_data;
                end else begin
                    rd_cnt--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                bus.memory_valid = 1'b1;
            end
            #1;
            if (m_reading) begin
                if (bus.memory_valid) m_reading = 1'b0;
            end else if (m_owner < 0) begin
                m_owner = rr_pick(m_last, bus.port_memory_enable);
                if (m_owner >= 0) begin
                    m_txn = pq[m_owner][0];
                    ec.port = m_owner;
                    ec.t = m_txn;
                    exp_cmd_q.push_back(ec);
                end
            end
            if (!m_reading && m_owner >= 0 && bus.memory_ready) begin
                m_last = m_owner;
                if (!m_txn.cmd) begin
                    m_reading = 1'b1;
                    rd_cnt = $urandom_range(0, 3);
                    rd_data = mem_fn(m_txn.ra);
                    er.port = m_owner;
                    er.data = rd_data;
                    exp_rd_q.push_back(er);
                end
                m_owner = -1;
            end
        end
        if (cyc >= 6000) check("timeout", 1, 0);
        repeat (3) begin
            @(posedge clk); #1;
            all_off();
            bus.memory_valid = 1'b0;
        end
        @(negedge clk);
        mon_on = 1'b0;
        check("cmd_queue_drained", exp_cmd_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single memory port (ready/valid, command/enable, split read/write address) among NUM_PORTS requesters: core instruction/data sides, DMA, debug.
- Sits between requesters and the memory; each upstream side has the same handshake as the memory, so a core connects unchanged.
- Round-robin arbitration; grant is locked while a request is pending; at most one read is outstanding.

Parameters:
NUM_PORTS, 2, number of requesters (>=2)
ADDRESS_WIDTH, 32, address width
DATA_WIDTH, 32, data width; mask width equals DATA_WIDTH (bit mask)
GRANT_WIDTH, $clog2(NUM_PORTS), grant index width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-low reset, sampled on rising clk
port_memory_enable  input  NUM_PORTS  per-port request
port_memory_command  input  NUM_PORTS  per-port command, 0=read 1=write
port_read_memory_address  input  NUM_PORTS*ADDRESS_WIDTH  port i at slice i
port_write_memory_address  input  NUM_PORTS*ADDRESS_WIDTH  port i at slice i
port_write_memory_data  input  NUM_PORTS*DATA_WIDTH  port i at slice i
port_write_memory_mask  input  NUM_PORTS*DATA_WIDTH  port i at slice i
port_memory_ready  output  NUM_PORTS  per-port accept
port_memory_valid  output  NUM_PORTS  per-port read-data valid pulse
port_read_memory_data  output  DATA_WIDTH  read data, broadcast to all ports
memory_ready  input  1  memory accepts a command this cycle
memory_valid  input  1  read data valid
read_memory_data  input  DATA_WIDTH  memory read data
memory_enable  output  1  request to memory
memory_command  output  1  0=read 1=write
read_memory_address  output  ADDRESS_WIDTH
write_memory_address  output  ADDRESS_WIDTH
write_memory_data  output  DATA_WIDTH
write_memory_mask  output  DATA_WIDTH
debug_grant  output  GRANT_WIDTH  current or last granted port
debug_state  output  2  0=IDLE 1=LOCKED 2=READ_WAIT

Behaviour:
- Transfer rule: a command is accepted in a cycle where memory_enable=1 and memory_ready=1.
- Writes complete on acceptance and produce no valid.
- A read completes on the first memory_valid after acceptance.
- Reset (reset=0 at a clk edge):
  - state=IDLE; last pointer=NUM_PORTS-1, so port 0 has first priority.
  - While state is IDLE with no request, all outputs are 0: memory_enable, port_memory_ready, port_memory_valid, and the address/data/mask outputs.
- IDLE:
  - Winner = first port with enable=1, searching from (last+1) mod NUM_PORTS upward with wrap-around.
  - The winner's command, addresses, data and mask are driven to memory combinationally (zero-cycle latency). memory_enable=1.
  - port_memory_ready[winner]=memory_ready; all other ports' ready=0.
  - Accepted write: stay IDLE, last<=winner.
  - Accepted read: go to READ_WAIT, owner<=winner.
  - Not accepted: go to LOCKED, owner<=winner.
  - No enables: memory_enable=0, pointer unchanged.
- LOCKED:
  - Grant is fixed to owner; owner's signals are forwarded exactly as in IDLE. Other ports cannot preempt it.
  - Accepted write: go to IDLE, last<=owner.
  - Accepted read: go to READ_WAIT.
  - Owner drops enable before acceptance: same cycle memory_enable=0; next cycle go to IDLE, last<=owner.
- READ_WAIT:
  - memory_enable=0 and all port_memory_ready=0.
  - On memory_valid: port_memory_valid[owner]=1 for that cycle; go to IDLE, last<=owner.
  - port_read_memory_data = read_memory_data at all times.
  - The next grant is decided in the cycle after the valid, so there is one idle bus cycle between reads.
- Any memory_valid outside READ_WAIT is ignored and never forwarded.
- Simultaneous requests: round-robin guarantees every requesting port is granted within NUM_PORTS transfers.
- Reset mid-operation: a pending lock or outstanding read is abandoned. A late memory_valid after reset is discarded, because the state is IDLE.
- debug_grant = winner in IDLE, owner otherwise. debug_state reflects the registered state.
- Fully synchronous; no combinational path from memory_valid to memory_enable.

Test Plan:
1. Reset held 0 for 2 cycles with all ports enabled -> memory_enable=0, all ready/valid 0. First cycle after release grants port 0.
2. NUM_PORTS=3, all ports issue back-to-back writes, memory_ready=1 -> grants 0,1,2,0,1,2. Outputs carry each port's write address, data and mask, e.g. port1 0x0000_1004/0xDEAD_BEEF/0xFFFF_FFFF.
3. Port 1 reads 0x100, memory_ready=1, memory_valid 3 cycles later with 0x1234_5678 -> READ_WAIT for 3 cycles, port_memory_valid=3'b010 for exactly one cycle, no other grant meanwhile.
4. Port 0 requests with memory_ready=0 for 4 cycles while port 1 also requests -> state LOCKED, grant stays 0, port 1 ready=0. Acceptance goes to port 0, then port 1 is granted.
5. Port 2 enters LOCKED, then drops enable -> memory_enable=0 that cycle; next arbitration starts from port 0.
6. Reset asserted in READ_WAIT, memory_valid arrives 1 cycle after release -> state IDLE, no port_memory_valid asserted.
